// File: rtl/count_sequencer.sv
// Day-count sequencer: two debounced pushbuttons start/pause the count and select
// slow/fast advance of a BCD day counter that runs 01..99 and wraps back to 01.
module count_sequencer #(
  parameter int SLOW_DIV = 10000000,
  parameter int FAST_DIV = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_run_n,
  input  logic       key_speed_n,
  output logic [3:0] lsd,
  output logic [3:0] msd,
  output logic       running,
  output logic       fast,
  output logic       tick,
  output logic       wrap,
  output logic       blink
);

  localparam int PW = $clog2(SLOW_DIV);
  localparam logic [PW-1:0] SLOW_LAST = PW'(SLOW_DIV - 1);
  localparam logic [PW-1:0] FAST_LAST = PW'(FAST_DIV - 1);

  typedef enum logic [1:0] {
    PAUSED   = 2'd0,
    RUN_SLOW = 2'd1,
    RUN_FAST = 2'd2
  } state_t;

  state_t        state;
  logic          speed_sel;
  logic [PW-1:0] prescale;
  logic [1:0]    run_sync;
  logic [1:0]    speed_sync;
  logic          run_prev;
  logic          speed_prev;
  logic          run_press;
  logic          speed_press;
  logic          speed_next;
  logic          at_last;

  // NOTE: every flop is written with <= so all registers sample the same
  // pre-edge values; blocking assignments here would chain the synchronizer
  // stages into a single flop in simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: loading the "pressed" level (0) means a key held through reset
      // looks already-pressed, so it must be released before it counts again.
      run_sync   <= '0;
      speed_sync <= '0;
      run_prev   <= 1'b0;
      speed_prev <= 1'b0;
    end else begin
      run_sync   <= {run_sync[0], key_run_n};
      speed_sync <= {speed_sync[0], key_speed_n};
      run_prev   <= run_sync[1];
      speed_prev <= speed_sync[1];
    end
  end

  // A press is the falling edge of the synchronized key, one cycle wide.
  assign run_press   = run_prev & ~run_sync[1];
  assign speed_press = speed_prev & ~speed_sync[1];
  assign speed_next  = speed_sel ^ speed_press;

  assign running = (state == RUN_SLOW) || (state == RUN_FAST);
  assign fast    = speed_sel;
  assign at_last = (prescale == ((state == RUN_FAST) ? FAST_LAST : SLOW_LAST));
  // Any press changes or leaves the run state, so it also cancels a pending tick.
  assign tick    = running & at_last & ~run_press & ~speed_press;
  assign wrap    = tick & (lsd == 4'd9) & (msd == 4'd9);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= PAUSED;
      speed_sel <= 1'b0;
      prescale  <= '0;
      lsd       <= 4'd1;
      msd       <= 4'd0;
      blink     <= 1'b0;
    end else begin
      speed_sel <= speed_next;

      case (state)
        PAUSED:
          if (run_press) state <= speed_next ? RUN_FAST : RUN_SLOW;
        RUN_SLOW, RUN_FAST:
          if (run_press)        state <= PAUSED;
          else if (speed_press) state <= speed_next ? RUN_FAST : RUN_SLOW;
        default:
          state <= PAUSED;
      endcase

      if (!running || run_press || speed_press || at_last) prescale <= '0;
      else                                                 prescale <= prescale + PW'(1);

      if (tick) begin
        blink <= ~blink;
        if (lsd != 4'd9) begin
          lsd <= lsd + 4'd1;
        end else if (msd != 4'd9) begin
          lsd <= 4'd0;
          msd <= msd + 4'd1;
        end else begin
          lsd <= 4'd1;
          msd <= 4'd0;
        end
      end
    end
  end

endmodule
